alu_cmd_driver: RTL and testbench

// Initiator side of the 8-bit ALU operand/select interface. Accepts operation

---
 rtl/alu_cmd_driver.sv | 127 ++++++++++++
 tb/tb_alu_cmd_driver.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_driver.sv
// Initiator for an 8-bit combinational ALU: queues tagged operation requests,
// issues them one at a time, and returns captured results with flags.
module alu_cmd_driver #(
  parameter  int DEPTH = 4,
  parameter  int TAG_W = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [7:0]       req_a,
  input  logic [7:0]       req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [2:0]       alu_sel,
  input  logic [7:0]       alu_out,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [CNT_W-1:0] fifo_count,
  output logic             busy
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [2:0]       op;
    logic [7:0]       a;
    logic [7:0]       b;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  req_t             mem [DEPTH];
  req_t             head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             empty;
  logic             push;
  logic             pop;
  state_t           state;
  logic [TAG_W-1:0] cur_tag;

  assign empty     = (fifo_count == '0);
  assign req_ready = reset_n & (fifo_count < FULL_CNT);
  assign push      = req_valid & req_ready;
  // Pop only when the ALU path is free: idle, or the current response is being taken.
  assign pop       = !empty && ((state == IDLE) || (state == RESP && rsp_ready));
  assign head      = mem[rd_ptr];
  assign busy      = (state != IDLE) || !empty;

  // NOTE: storage array has no reset; occupancy is tracked by the pointers/count,
  // so stale contents are never observed and the array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{op: req_op, a: req_a, b: req_b, tag: req_tag};
  end

  // NOTE: every sequential assignment is non-blocking so all registers update
  // from pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      cur_tag    <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_tag    <= '0;
    end else begin
      if (pop) begin
        alu_a   <= head.a;
        alu_b   <= head.b;
        alu_sel <= head.op;
        cur_tag <= head.tag;
      end
      case (state)
        IDLE: begin
          if (pop) state <= ISSUE;
        end
        ISSUE: begin
          rsp_result <= alu_out;
          rsp_carry  <= alu_carry & ((alu_sel == 3'b000) || (alu_sel == 3'b001));
          rsp_zero   <= (alu_out == 8'h00);
          rsp_tag    <= cur_tag;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= pop ? ISSUE : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Self-checking bench for alu_cmd_driver: behavioural ALU, table-driven vectors,
// scoreboard of expected responses, and hand sequences for the multi-cycle corners.
module tb_alu_cmd_driver;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [2:0]       req_op = '0;
  logic [7:0]       req_a = '0;
  logic [7:0]       req_b = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic [2:0]       alu_sel;
  logic [7:0]       alu_out;
  logic             alu_carry;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [7:0]       rsp_result;
  logic             rsp_carry;
  logic             rsp_zero;
  logic [TAG_W-1:0] rsp_tag;
  logic [CNT_W-1:0] fifo_count;
  logic             busy;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0]       result;
    logic             carry;
    logic             zero;
    logic [TAG_W-1:0] tag;
  } exp_t;

  typedef struct {
    logic [2:0]       op;
    logic [7:0]       a;
    logic [7:0]       b;
    logic [TAG_W-1:0] tag;
    logic [7:0]       result;
    logic             carry;
    logic             zero;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[9];

  alu_cmd_driver #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_tag(rsp_tag),
    .fifo_count(fifo_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; logic ops raise carry on purpose so the driver's masking is visible.
  function automatic logic [8:0] alu_fn(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b);
    case (sel)
      3'b000:  return {1'b0, a} + {1'b0, b};
      3'b001:  return {1'b0, a} - {1'b0, b};
      3'b010:  return {1'b1, a & b};
      3'b011:  return {1'b1, a | b};
      3'b100:  return {1'b1, a ^ b};
      3'b101:  return {1'b1, ~(a & b)};
      3'b110:  return {1'b1, ~(a ^ b)};
      default: return {1'b1, ~(a | b)};
    endcase
  endfunction

  assign {alu_carry, alu_out} = alu_fn(alu_sel, alu_a, alu_b);

  function automatic exp_t mk_exp(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                  input logic [TAG_W-1:0] tag);
    logic [8:0] r;
    exp_t e;
    r = alu_fn(op, a, b);
    e.result = r[7:0];
    e.carry  = (op == 3'b000 || op == 3'b001) ? r[8] : 1'b0;
    e.zero   = (r[7:0] == 8'h00);
    e.tag    = tag;
    return e;
  endfunction

  function automatic exp_t tab_exp(input vec_t v);
    exp_t e;
    e.result = v.result;
    e.carry  = v.carry;
    e.zero   = v.zero;
    e.tag    = v.tag;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Inputs change at posedge+1; a request is taken if ready is seen at the negedge before the edge.
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [TAG_W-1:0] tag, input exp_t e);
    int  waited;
    bit  ok;
    waited    = 0;
    ok        = 1'b0;
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    while (!ok && waited < 100) begin
      @(negedge clk);
      ok = req_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    req_valid = 1'b0;
    check("req_accepted", {31'd0, ok}, 32'd1);
    if (ok) sb.push_back(e);
  endtask

  task automatic send_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                            input logic [TAG_W-1:0] tag);
    send(op, a, b, tag, mk_exp(op, a, b, tag));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_done", {31'd0, (sb.size() == 0 && !busy)}, 32'd1);
  endtask

  // Scoreboard side: every completed response handshake is compared in order.
  always @(negedge clk) begin
    if (reset_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_result", {24'd0, rsp_result}, {24'd0, mon_e.result});
        check("rsp_carry",  {31'd0, rsp_carry},  {31'd0, mon_e.carry});
        check("rsp_zero",   {31'd0, rsp_zero},   {31'd0, mon_e.zero});
        check("rsp_tag",    {28'd0, rsp_tag},    {28'd0, mon_e.tag});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{3'b000, 8'd200, 8'd100, 4'd3,  8'd44,  1'b1, 1'b0};
    vecs[1] = '{3'b001, 8'd5,   8'd10,  4'd4,  8'd251, 1'b1, 1'b0};
    vecs[2] = '{3'b001, 8'd10,  8'd5,   4'd5,  8'd5,   1'b0, 1'b0};
    vecs[3] = '{3'b010, 8'hF0,  8'h0F,  4'd6,  8'h00,  1'b0, 1'b1};
    vecs[4] = '{3'b111, 8'h00,  8'h00,  4'd7,  8'hFF,  1'b0, 1'b0};
    vecs[5] = '{3'b000, 8'hFF,  8'h01,  4'd8,  8'h00,  1'b1, 1'b1};
    vecs[6] = '{3'b100, 8'hAA,  8'hAA,  4'd9,  8'h00,  1'b0, 1'b1};
    vecs[7] = '{3'b011, 8'h12,  8'h34,  4'd10, 8'h36,  1'b0, 1'b0};
    vecs[8] = '{3'b001, 8'h00,  8'h00,  4'd11, 8'h00,  1'b0, 1'b1};

    // Reset state
    #3;
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_count", {29'd0, fifo_count}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("post_rst_alu_a", {24'd0, alu_a}, 32'd0);
    rsp_ready = 1'b1;

    // Latency: accept at E0, operands after E1, response after E2
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_op = vecs[0].op; req_a = vecs[0].a; req_b = vecs[0].b; req_tag = vecs[0].tag;
    @(negedge clk);
    check("lat_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    sb.push_back(tab_exp(vecs[0]));
    check("lat_e0_count", {29'd0, fifo_count}, 32'd1);
    check("lat_e0_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("lat_e1_alu_a", {24'd0, alu_a}, 32'd200);
    check("lat_e1_alu_b", {24'd0, alu_b}, 32'd100);
    check("lat_e1_alu_sel", {29'd0, alu_sel}, 32'd0);
    check("lat_e1_valid", {31'd0, rsp_valid}, 32'd0);
    check("lat_e1_busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    check("lat_e2_valid", {31'd0, rsp_valid}, 32'd1);
    wait_drain();

    // Table vectors, back to back
    for (int i = 1; i < 9; i++) send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, tab_exp(vecs[i]));
    wait_drain();

    // Backpressure: 4 queued + 1 in RESP, then response held stable
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_model(3'(i), 8'(8'h10 * i + 3), 8'h07, 4'(i + 1));
      if (i == 3) begin
        check("bp_count_3", {29'd0, fifo_count}, 32'd3);
        check("bp_ready_3", {31'd0, req_ready}, 32'd1);
      end
    end
    check("bp_full_ready", {31'd0, req_ready}, 32'd0);
    check("bp_full_count", {29'd0, fifo_count}, 32'd4);
    repeat (3) @(posedge clk);
    #1;
    check("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
    check("bp_hold_tag", {28'd0, rsp_tag}, {28'd0, sb[0].tag});
    check("bp_hold_result", {24'd0, rsp_result}, {24'd0, sb[0].result});
    check("bp_hold_count", {29'd0, fifo_count}, 32'd4);
    rsp_ready = 1'b1;
    wait_drain();

    // Simultaneous push and pop at count = DEPTH-1
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_model(3'(i + 2), 8'(8'h21 * i), 8'h5A, 4'(i + 8));
    check("pp_count_before", {29'd0, fifo_count}, 32'd3);
    rsp_ready = 1'b1;
    send_model(3'b000, 8'h80, 8'h80, 4'd15);
    check("pp_count_after", {29'd0, fifo_count}, 32'd3);
    wait_drain();

    // Long stream so both pointers wrap several times
    for (int i = 0; i < 12; i++)
      send_model(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 4'(i));
    wait_drain();

    // Reset while ISSUE with two requests still queued
    rsp_ready = 1'b0;
    send_model(3'b000, 8'd1, 8'd2, 4'd1);
    send_model(3'b011, 8'h40, 8'h01, 4'd2);
    send_model(3'b100, 8'h0F, 8'hF0, 4'd3);
    send_model(3'b000, 8'd9, 8'd9, 4'd4);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_alu_a", {24'd0, alu_a}, 32'h40);
    check("rst_mid_count", {29'd0, fifo_count}, 32'd2);
    reset_n = 1'b0;
    sb.delete();
    #1;
    check("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_mid_rsp_result", {24'd0, rsp_result}, 32'd0);
    check("rst_mid_rsp_tag", {28'd0, rsp_tag}, 32'd0);
    check("rst_mid_alu_a0", {24'd0, alu_a}, 32'd0);
    check("rst_mid_alu_b0", {24'd0, alu_b}, 32'd0);
    check("rst_mid_alu_sel0", {29'd0, alu_sel}, 32'd0);
    check("rst_mid_count0", {29'd0, fifo_count}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_req_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    check("rst_rel_req_ready", {31'd0, req_ready}, 32'd1);
    repeat (6) @(posedge clk);
    #1;
    check("rst_rel_no_rsp", {31'd0, rsp_valid}, 32'd0);
    check("rst_rel_idle", {31'd0, busy}, 32'd0);
    send_model(3'b001, 8'd3, 8'd7, 4'd6);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
